// File: rtl/shift_operand_engine_if.sv
// shift_operand_engine_if: request and result handshake bundle for the shifter-operand engine
interface shift_operand_engine_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             imm_mode;
    logic [11:0]      operand;
    logic [WIDTH-1:0] value;
    logic [7:0]       rs_amount;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    modport master (
        output in_valid, imm_mode, operand, value, rs_amount, carry_in, out_ready,
        input  in_ready, out_valid, out_result, out_carry
    );
    modport slave (
        input  in_valid, imm_mode, operand, value, rs_amount, carry_in, out_ready,
        output in_ready, out_valid, out_result, out_carry
    );
endinterface

// File: rtl/shift_operand_engine.sv
// shift_operand_engine: iterative ARM shifter operand, STEP bits per cycle; SHIFTER_CARRY_EN enables carry-out tracking
module shift_operand_engine #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input logic                 clk,
    input logic                 reset,
    shift_operand_engine_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = CW > 9 ? CW : 9;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {LSL, LSR, ASR, ROR, RRX} shift_t;
    state_t           state_q, state_d;
    shift_t           typ_q, typ_d;
    logic [WIDTH-1:0] val_q, val_d, step_val;
    logic [CW-1:0]    rem_q, n_d, k;
    logic [AW-1:0]    amt_d;
    logic             imm_zero, accept, stepping, cin_q, unused;
    // operand[3:0] names Rm, whose contents already arrive on value
    assign unused   = ^bus.operand[3:0];
    assign accept   = state_q == IDLE && bus.in_valid;
    assign stepping = state_q == SHIFT && rem_q != '0;
    assign imm_zero = !bus.operand[4] && bus.operand[11:7] == 5'd0;
    always_comb begin
        typ_d = bus.imm_mode ? ROR : (bus.operand[6:5] == 2'b11 && imm_zero) ? RRX : shift_t'({1'b0, bus.operand[6:5]});
        amt_d = bus.imm_mode ? AW'({bus.operand[11:8], 1'b0}) : bus.operand[4] ? AW'(bus.rs_amount) :
                (imm_zero && (typ_d == LSR || typ_d == ASR)) ? AW'(WIDTH) : AW'(bus.operand[11:7]);
        n_d = typ_d == RRX ? CW'(1) : typ_d == ROR ? CW'(amt_d[CW-2:0]) : amt_d > AW'(WIDTH) ? CW'(WIDTH) : CW'(amt_d);
        val_d = bus.imm_mode ? WIDTH'(bus.operand[7:0]) : bus.value;
        k = rem_q > CW'(STEP) ? CW'(STEP) : rem_q;
        step_val = typ_q == LSL ? val_q << k :
                   typ_q == LSR ? val_q >> k :
                   typ_q == ASR ? WIDTH'($signed(val_q) >>> k) :
                   typ_q == ROR ? (val_q >> k) | (val_q << (CW'(WIDTH) - k)) :
                   {cin_q, val_q[WIDTH-1:1]};
        state_d = accept ? SHIFT : (state_q == SHIFT && rem_q == '0) ? DONE :
                  (state_q == DONE && bus.out_ready) ? IDLE : state_q;
    end
    assign bus.in_ready   = state_q == IDLE;
    assign bus.out_valid  = state_q == DONE;
    assign bus.out_result = val_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            typ_q   <= LSL;
            val_q   <= '0;
            rem_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                typ_q <= typ_d;
                val_q <= val_d;
                rem_q <= n_d;
                cin_q <= bus.carry_in;
            end else if (stepping) begin
                val_q <= step_val;
                rem_q <= rem_q - k;
            end
        end
    end
`ifdef SHIFTER_CARRY_EN
    logic             carry_q, over_q, over_d, carry_d, step_carry;
    logic [WIDTH-1:0] lsl_t, rsh_t;
    always_comb begin
        over_d = (typ_d == LSL || typ_d == LSR || typ_d == ASR) && amt_d > AW'(WIDTH);
        // rotates with a nonzero amount report the new top bit even when n wraps to 0
        carry_d = typ_d == ROR && amt_d != '0 ? val_d[WIDTH-1] : bus.carry_in;
        lsl_t = val_q << (k - CW'(1));
        rsh_t = val_q >> (k - CW'(1));
        step_carry = over_q && typ_q != ASR ? 1'b0 : typ_q == LSL ? lsl_t[WIDTH-1] : rsh_t[0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            over_q  <= 1'b0;
        end else if (accept) begin
            carry_q <= carry_d;
            over_q  <= over_d;
        end else if (stepping) begin
            carry_q <= step_carry;
        end
    end
    assign bus.out_carry = carry_q;
`else
    assign bus.out_carry = 1'b0;
`endif
endmodule

// File: tb/tb_shift_operand_engine.sv
// tb_shift_operand_engine: directed vector table plus reset and back-pressure sequences
module tb_shift_operand_engine;
    localparam int STEP = 1;
`ifdef SHIFTER_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif
    typedef struct packed {
        logic        imm;
        logic [11:0] op;
        logic [31:0] val;
        logic [7:0]  rs;
        logic        cin;
        logic [31:0] res;
        logic        c;
        logic [7:0]  n;
    } vec_t;

    logic clk, reset;
    int   checks, errors;
    vec_t vecs [0:16];

    shift_operand_engine_if #(.WIDTH(32)) bus ();
    shift_operand_engine #(.WIDTH(32), .STEP(STEP)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.imm_mode  = v.imm;
        bus.operand   = v.op;
        bus.value     = v.val;
        bus.rs_amount = v.rs;
        bus.carry_in  = v.cin;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat <= 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_out(input string nm);
        @(negedge clk) bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({nm, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b1, 12'h4FF, 32'h0,        8'd0,  1'b0, 32'hFF000000, 1'b1, 8'd8};
        vecs[1]  = '{1'b0, 12'h080, 32'h2,        8'd0,  1'b0, 32'h4,        1'b0, 8'd1};
        vecs[2]  = '{1'b0, 12'h050, 32'h80000000, 8'd40, 1'b0, 32'hFFFFFFFF, 1'b1, 8'd32};
        vecs[3]  = '{1'b0, 12'h060, 32'h3,        8'd0,  1'b1, 32'h80000001, 1'b1, 8'd1};
        vecs[4]  = '{1'b0, 12'h030, 32'hFFFFFFFF, 8'd33, 1'b1, 32'h0,        1'b0, 8'd32};
        vecs[5]  = '{1'b0, 12'h030, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 12'h020, 32'h80000000, 8'd0,  1'b0, 32'h0,        1'b1, 8'd32};
        vecs[7]  = '{1'b0, 12'h040, 32'h7FFFFFFF, 8'd0,  1'b1, 32'h0,        1'b0, 8'd32};
        vecs[8]  = '{1'b0, 12'h070, 32'h80000001, 8'd32, 1'b0, 32'h80000001, 1'b1, 8'd0};
        vecs[9]  = '{1'b0, 12'h260, 32'h0000001F, 8'd0,  1'b0, 32'hF0000001, 1'b1, 8'd4};
        vecs[10] = '{1'b0, 12'h010, 32'h1,        8'd32, 1'b0, 32'h0,        1'b1, 8'd32};
        vecs[11] = '{1'b0, 12'h010, 32'h1,        8'd33, 1'b1, 32'h0,        1'b0, 8'd32};
        vecs[12] = '{1'b1, 12'h0AB, 32'h0,        8'd0,  1'b1, 32'h000000AB, 1'b1, 8'd0};
        vecs[13] = '{1'b0, 12'h220, 32'h000000F8, 8'd0,  1'b0, 32'h0000000F, 1'b1, 8'd4};
        vecs[14] = '{1'b0, 12'h050, 32'h80000008, 8'd4,  1'b0, 32'hF8000000, 1'b1, 8'd4};
        vecs[15] = '{1'b0, 12'h000, 32'hDEADBEEF, 8'd0,  1'b1, 32'hDEADBEEF, 1'b1, 8'd0};
        vecs[16] = '{1'b0, 12'h070, 32'h0000000F, 8'd36, 1'b0, 32'hF0000000, 1'b1, 8'd4};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.imm_mode = 1'b0; bus.operand = '0; bus.value = '0;
        bus.rs_amount = '0; bus.carry_in = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_carry", 32'(bus.out_carry), 32'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            start(vecs[i]);
            wait_valid(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(1 + (int'(vecs[i].n) + STEP - 1) / STEP));
            chk($sformatf("v%0d_res", i), bus.out_result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), 32'(bus.out_carry), 32'(CEN ? vecs[i].c : 1'b0));
            release_out($sformatf("v%0d", i));
        end

        // reset while shifting abandons the request
        start(vecs[4]);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_result", bus.out_result, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("midrst_no_output", 32'(bus.out_valid), 32'd0);

        // back-pressure in DONE, then no accept on the DONE->IDLE edge
        start(vecs[1]);
        wait_valid(lat);
        held = bus.out_result;
        chk("hold_first", held, 32'h4);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_valid", j), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d_ready", j), 32'(bus.in_ready), 32'd0);
            chk($sformatf("hold%0d_res", j), bus.out_result, held);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.imm_mode  = vecs[12].imm;
        bus.operand   = vecs[12].op;
        bus.carry_in  = vecs[12].cin;
        @(posedge clk);
        #1;
        chk("drain_ready", 32'(bus.in_ready), 32'd1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("next_accept", 32'(bus.in_ready), 32'd0);
        wait_valid(lat);
        chk("next_lat", 32'(lat), 32'd1);
        chk("next_res", bus.out_result, 32'h000000AB);
        release_out("next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
